// File: rtl/eth_tx_frame_arbiter_if.sv
// ---------------------------------------------------------------------------
// eth_tx_frame_arbiter_if
// Purpose : 8-bit AXI-Stream byte channel used for the cmd and dat frame
//           sources and for the MAC transmit port of eth_tx_frame_arbiter.
// Signals : tdata  [7:0]  frame byte
//           tvalid        byte valid
//           tlast         last byte of frame
//           tready        byte accepted by the sink
// Modports: master - drives tdata/tvalid/tlast, receives tready
//           slave  - receives tdata/tvalid/tlast, drives tready
// ---------------------------------------------------------------------------
interface eth_tx_frame_arbiter_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tlast;
  logic       tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/eth_tx_frame_arbiter.sv
// ---------------------------------------------------------------------------
// eth_tx_frame_arbiter
// Purpose : Packet-level arbiter sharing the single 8-bit Ethernet TX stream
//           to the MAC between the command decoder's response frames (cmd)
//           and the ADC sample-data framer (dat). Frames are never
//           interleaved; cmd has priority, but after STARVE_LIMIT cmd frames
//           granted while dat was waiting, dat is forced through. An
//           inter-frame gap of IFG_CYCLES idle cycles follows every frame.
// Parameters:
//   IFG_CYCLES    idle cycles after each frame's tlast beat (0 = no gap)
//   STARVE_LIMIT  cmd frames granted over a waiting dat before dat wins (>=1)
// Ports   :
//   gtx_clk_bufg     in   125 MHz clock, all logic on this clock
//   gtx_resetn       in   asynchronous active-low reset
//   s_cmd_axis       slave  cmd frame stream (tdata/tvalid/tlast in, tready out)
//   s_dat_axis       slave  dat frame stream (tdata/tvalid/tlast in, tready out)
//   tx_axis          master stream to the MAC (tready in)
//   grant_cmd        out  registered: cmd owns tx_axis
//   grant_dat        out  registered: dat owns tx_axis
//   cmd_frame_count  out  completed cmd frames (wraps)
//   dat_frame_count  out  completed dat frames (wraps)
// ---------------------------------------------------------------------------
module eth_tx_frame_arbiter #(
  parameter int IFG_CYCLES   = 12,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                          gtx_clk_bufg,
  input  logic                          gtx_resetn,
  eth_tx_frame_arbiter_if.slave         s_cmd_axis,
  eth_tx_frame_arbiter_if.slave         s_dat_axis,
  eth_tx_frame_arbiter_if.master        tx_axis,
  output logic                          grant_cmd,
  output logic                          grant_dat,
  output logic [15:0]                   cmd_frame_count,
  output logic [15:0]                   dat_frame_count
);

  localparam int GAP_W    = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [GAP_W-1:0]    GAP_LAST   = GAP_W'(IFG_CYCLES > 0 ? IFG_CYCLES - 1 : 0);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_CMD = 2'd1,
    GNT_DAT = 2'd2,
    GAP     = 2'd3
  } state_t;

  state_t                state_reg, state_next;
  logic [GAP_W-1:0]      gap_cnt_reg;
  logic [STARVE_W-1:0]   starve_cnt_reg;
  logic                  dat_waiting_reg;
  logic                  grant_cmd_reg, grant_dat_reg;
  logic [15:0]           cmd_cnt_reg, dat_cnt_reg;

  logic starve_hit;
  logic cmd_wins, dat_wins;
  logic cmd_last_fire, dat_last_fire;
  logic gap_done;

  // starve_cnt saturates at STARVE_MAX, so "== MAX" is the same as "not below the limit"
  assign starve_hit    = (starve_cnt_reg == STARVE_MAX);
  assign cmd_wins      = s_cmd_axis.tvalid & (~s_dat_axis.tvalid | ~starve_hit);
  assign dat_wins      = s_dat_axis.tvalid & ~cmd_wins;
  assign cmd_last_fire = (state_reg == GNT_CMD) & s_cmd_axis.tvalid & s_cmd_axis.tlast & tx_axis.tready;
  assign dat_last_fire = (state_reg == GNT_DAT) & s_dat_axis.tvalid & s_dat_axis.tlast & tx_axis.tready;
  assign gap_done      = (gap_cnt_reg == GAP_LAST);

  assign grant_cmd       = grant_cmd_reg;
  assign grant_dat       = grant_dat_reg;
  assign cmd_frame_count = cmd_cnt_reg;
  assign dat_frame_count = dat_cnt_reg;

  // FSM state register
  always_ff @(posedge gtx_clk_bufg or negedge gtx_resetn) begin
    if (!gtx_resetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (cmd_wins) begin
          state_next = GNT_CMD;
        end else if (dat_wins) begin
          state_next = GNT_DAT;
        end
      end
      GNT_CMD: begin
        if (cmd_last_fire) begin
          state_next = (IFG_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GNT_DAT: begin
        if (dat_last_fire) begin
          state_next = (IFG_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: the granted source is wired straight through to the MAC,
  // everything is quiet otherwise (including during the gap)
  always_comb begin
    tx_axis.tdata     = 8'h00;
    tx_axis.tvalid    = 1'b0;
    tx_axis.tlast     = 1'b0;
    s_cmd_axis.tready = 1'b0;
    s_dat_axis.tready = 1'b0;
    case (state_reg)
      GNT_CMD: begin
        tx_axis.tdata     = s_cmd_axis.tdata;
        tx_axis.tvalid    = s_cmd_axis.tvalid;
        tx_axis.tlast     = s_cmd_axis.tlast;
        s_cmd_axis.tready = tx_axis.tready;
      end
      GNT_DAT: begin
        tx_axis.tdata     = s_dat_axis.tdata;
        tx_axis.tvalid    = s_dat_axis.tvalid;
        tx_axis.tlast     = s_dat_axis.tlast;
        s_dat_axis.tready = tx_axis.tready;
      end
      default: ;
    endcase
  end

  // Grants, frame counters, gap timer and starvation guard
  always_ff @(posedge gtx_clk_bufg or negedge gtx_resetn) begin
    if (!gtx_resetn) begin
      grant_cmd_reg   <= 1'b0;
      grant_dat_reg   <= 1'b0;
      cmd_cnt_reg     <= 16'd0;
      dat_cnt_reg     <= 16'd0;
      gap_cnt_reg     <= '0;
      starve_cnt_reg  <= '0;
      dat_waiting_reg <= 1'b0;
    end else begin
      grant_cmd_reg <= (state_next == GNT_CMD);
      grant_dat_reg <= (state_next == GNT_DAT);

      if (cmd_last_fire) begin
        cmd_cnt_reg <= cmd_cnt_reg + 16'd1;
      end
      if (dat_last_fire) begin
        dat_cnt_reg <= dat_cnt_reg + 16'd1;
      end

      if ((state_reg == GAP) && !gap_done) begin
        gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
      end else begin
        gap_cnt_reg <= '0;
      end

      // Remember whether dat was already waiting when cmd won; only those
      // cmd frames count against dat.
      if ((state_reg == IDLE) && cmd_wins) begin
        dat_waiting_reg <= s_dat_axis.tvalid;
      end

      if ((state_reg == IDLE) && dat_wins) begin
        starve_cnt_reg <= '0;
      end else if (cmd_last_fire && dat_waiting_reg && !starve_hit) begin
        starve_cnt_reg <= starve_cnt_reg + STARVE_W'(1);
      end
    end
  end

endmodule
